// File: rtl/sa2_fsm.sv
// sa2_fsm: controller for a 2-way set-associative cache over a 4-word-line memory.
// Processor side: addr/data_in/rd/wr in; data_out/done/stall/cache_hit out.
// Cache side: c_en/c_index/c_offset/c_tag_in/c_data_in/c_comp/c_write/c_valid_in out;
//   c_hit/c_dirty/c_valid/c_tag_out*/c_data_out* in.
// Memory side: m_addr/m_data_in/m_wr/m_rd out; m_data_out/m_stall in.
module sa2_fsm #(
  parameter int RD_LAT = 2,
  parameter int NUM_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        cache_hit,
  output logic [1:0]  c_en,
  output logic [7:0]  c_index,
  output logic [2:0]  c_offset,
  output logic [4:0]  c_tag_in,
  output logic [15:0] c_data_in,
  output logic        c_comp,
  output logic        c_write,
  output logic        c_valid_in,
  input  logic [1:0]  c_hit,
  input  logic [1:0]  c_dirty,
  input  logic [1:0]  c_valid,
  input  logic [4:0]  c_tag_out0,
  input  logic [4:0]  c_tag_out1,
  input  logic [15:0] c_data_out0,
  input  logic [15:0] c_data_out1,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_wr,
  output logic        m_rd,
  input  logic [15:0] m_data_out,
  input  logic        m_stall
);
  typedef enum logic [1:0] {IDLE, WB, ALLOC, RETRY} state_t;
  state_t state, state_nx;
  logic victimway, vic, l_wr, issue;
  logic [15:0] l_addr, l_data;
  logic [2:0] cnt, cnt_nx;
  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0][1:0] pw;
  logic req, hit0, hit1, vsel, fill;
  logic [1:0] vic_oh, lw;
  logic [4:0] vtag;
  logic [15:0] vdata;
  assign req = rd | wr;
  assign hit0 = c_hit[0] & c_valid[0];
  assign hit1 = c_hit[1] & c_valid[1];
  // first invalid way wins; with both valid fall back to the round-robin bit
  assign vsel = !c_valid[0] ? 1'b0 : !c_valid[1] ? 1'b1 : victimway;
  assign vic_oh = vic ? 2'b10 : 2'b01;
  assign vtag = vic ? c_tag_out1 : c_tag_out0;
  assign vdata = vic ? c_data_out1 : c_data_out0;
  // the oldest delay-line stage marks a memory word arriving this cycle
  assign lw = pw[RD_LAT-1];
  assign fill = (state == ALLOC) && pv[RD_LAT-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      victimway <= 1'b0;
      vic <= 1'b0;
      l_wr <= 1'b0;
      l_addr <= '0;
      l_data <= '0;
      cnt <= '0;
      pv <= '0;
      pw <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      pv <= {pv[RD_LAT-2:0], issue & ~m_stall};
      pw <= {pw[RD_LAT-2:0], cnt[1:0]};
      if (state == IDLE && req) begin
        victimway <= ~victimway;
        vic <= vsel;
        l_addr <= addr;
        l_data <= data_in;
        l_wr <= wr;
      end
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    issue = 1'b0;
    data_out = '0;
    done = 1'b0;
    stall = 1'b0;
    cache_hit = 1'b0;
    c_en = '0;
    c_index = '0;
    c_offset = '0;
    c_tag_in = '0;
    c_data_in = '0;
    c_comp = 1'b0;
    c_write = 1'b0;
    c_valid_in = 1'b0;
    m_addr = '0;
    m_data_in = '0;
    m_wr = 1'b0;
    m_rd = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (req) begin
          c_en = 2'b11;
          c_comp = 1'b1;
          c_write = wr;
          c_tag_in = addr[15:11];
          c_index = addr[10:3];
          c_offset = addr[2:0];
          c_data_in = data_in;
          if (hit0 | hit1) begin
            done = 1'b1;
            cache_hit = 1'b1;
            data_out = hit0 ? c_data_out0 : c_data_out1;
          end else begin
            stall = 1'b1;
            state_nx = (c_valid[vsel] & c_dirty[vsel]) ? WB : ALLOC;
          end
        end
      end
      WB: begin
        stall = 1'b1;
        c_en = vic_oh;
        c_index = l_addr[10:3];
        c_offset = {cnt[1:0], 1'b0};
        m_wr = 1'b1;
        m_addr = {vtag, l_addr[10:3], cnt[1:0], 1'b0};
        m_data_in = vdata;
        if (!m_stall) begin
          cnt_nx = (cnt[1:0] == 2'(NUM_WORDS - 1)) ? 3'd0 : cnt + 3'd1;
          state_nx = (cnt[1:0] == 2'(NUM_WORDS - 1)) ? ALLOC : WB;
        end
      end
      ALLOC: begin
        stall = 1'b1;
        issue = cnt < 3'(NUM_WORDS);
        m_rd = issue;
        m_addr = {l_addr[15:3], cnt[1:0], 1'b0};
        cnt_nx = (issue && !m_stall) ? cnt + 3'd1 : cnt;
        c_index = l_addr[10:3];
        if (fill) begin
          c_en = vic_oh;
          c_write = 1'b1;
          c_valid_in = 1'b1;
          c_tag_in = l_addr[15:11];
          c_offset = {lw, 1'b0};
          c_data_in = m_data_out;
          // returns arrive in issue order, so the last word closes the refill
          state_nx = (lw == 2'(NUM_WORDS - 1)) ? RETRY : ALLOC;
        end
      end
      RETRY: begin
        stall = 1'b1;
        c_en = vic_oh;
        c_comp = 1'b1;
        c_write = l_wr;
        c_tag_in = l_addr[15:11];
        c_index = l_addr[10:3];
        c_offset = l_addr[2:0];
        c_data_in = l_data;
        done = 1'b1;
        data_out = vdata;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sa2_fsm.sv
// tb_sa2_fsm: randomized self-checking bench with cache/memory models and a cache-level reference.
module tb_sa2_fsm;
  logic clk = 1'b0, rst = 1'b1, rd = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, data_in = '0;
  logic [15:0] data_out, m_addr, m_data_in, m_data_out, c_data_in, c_data_out0, c_data_out1;
  logic done, stall, cache_hit, c_comp, c_write, c_valid_in, m_wr, m_rd, m_stall;
  logic [1:0] c_en, c_hit, c_dirty, c_valid;
  logic [7:0] c_index;
  logic [2:0] c_offset;
  logic [4:0] c_tag_in, c_tag_out0, c_tag_out1;
  int tests = 0, fails = 0, cyc = 0, t0 = 0, fc = 0;
  logic sen = 1'b0;
  logic [31:0] smask = '0;
  logic cv [2][256];
  logic cdy [2][256];
  logic [4:0] ctg [2][256];
  logic [15:0] cdt [2][256][4];
  logic [15:0] mem [32768];
  logic [1:0] rpv = '0;
  logic [14:0] rpa [2];
  logic [15:0] wr_log [$];
  logic [15:0] rd_log [$];
  bit rv [2][256];
  bit rdy [2][256];
  logic [4:0] rt [2][256];
  bit rvw = 1'b0;
  logic [15:0] gold [32768];

  sa2_fsm dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
    .data_out(data_out), .done(done), .stall(stall), .cache_hit(cache_hit),
    .c_en(c_en), .c_index(c_index), .c_offset(c_offset), .c_tag_in(c_tag_in),
    .c_data_in(c_data_in), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
    .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out0(c_tag_out0),
    .c_tag_out1(c_tag_out1), .c_data_out0(c_data_out0), .c_data_out1(c_data_out1),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_wr(m_wr), .m_rd(m_rd),
    .m_data_out(m_data_out), .m_stall(m_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    int rel;
    rel = cyc - t0;
    m_stall = sen && rel >= 0 && rel < 32 && smask[rel[4:0]];
  end

  always_comb begin
    c_valid = {cv[1][c_index], cv[0][c_index]};
    c_dirty = {cdy[1][c_index], cdy[0][c_index]};
    c_tag_out0 = ctg[0][c_index];
    c_tag_out1 = ctg[1][c_index];
    c_data_out0 = cdt[0][c_index][c_offset[2:1]];
    c_data_out1 = cdt[1][c_index][c_offset[2:1]];
    c_hit[0] = c_en[0] && c_comp && ctg[0][c_index] == c_tag_in;
    c_hit[1] = c_en[1] && c_comp && ctg[1][c_index] == c_tag_in;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (c_en[i] && c_write) begin
        if (!c_comp) begin
          cdt[i][c_index][c_offset[2:1]] <= c_data_in;
          ctg[i][c_index] <= c_tag_in;
          cv[i][c_index] <= c_valid_in;
          cdy[i][c_index] <= 1'b0;
        end else if (cv[i][c_index] && ctg[i][c_index] == c_tag_in) begin
          cdt[i][c_index][c_offset[2:1]] <= c_data_in;
          cdy[i][c_index] <= 1'b1;
        end
      end
    if (|c_en && c_write && !c_comp) fc <= fc + 1;
  end

  assign m_data_out = rpv[1] ? mem[rpa[1]] : 16'h0;
  always @(posedge clk) begin
    rpv <= {rpv[0], m_rd & ~m_stall};
    rpa[0] <= m_addr[15:1];
    rpa[1] <= rpa[0];
    if (m_wr && !m_stall) begin
      mem[m_addr[15:1]] <= m_data_in;
      wr_log.push_back(m_addr);
    end
    if (m_rd && !m_stall) rd_log.push_back(m_addr);
  end

  task automatic op(input bit w, input bit both, input logic [15:0] a, input logic [15:0] d, input int extra);
    logic [7:0] ix;
    logic [4:0] tg, ot;
    int hw, v, exp_lat, lat;
    bit ev, bad;
    ix = a[10:3];
    tg = a[15:11];
    hw = -1;
    for (int i = 0; i < 2; i++) if (rv[i][ix] && rt[i][ix] == tg) hw = i;
    v = !rv[0][ix] ? 0 : !rv[1][ix] ? 1 : int'(rvw);
    ev = hw < 0 && rv[v][ix] && rdy[v][ix];
    ot = rt[v][ix];
    exp_lat = hw >= 0 ? 0 : (ev ? 11 : 7) + extra;
    wr_log.delete();
    rd_log.delete();
    t0 = cyc;
    rd = !w || both;
    wr = w;
    addr = a;
    data_in = d;
    lat = 0;
    #1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (lat != exp_lat) begin fails++; $display("FAIL latency addr=%h got %0d expected %0d", a, lat, exp_lat); end
    tests++;
    if (cache_hit !== (hw >= 0)) begin fails++; $display("FAIL cache_hit addr=%h got %b expected %b", a, cache_hit, hw >= 0); end
    if (!w) begin
      tests++;
      if (data_out !== gold[a[15:1]]) begin fails++; $display("FAIL read_data addr=%h got %h expected %h", a, data_out, gold[a[15:1]]); end
    end
    if (both) begin
      tests++;
      if (c_write !== 1'b1) begin fails++; $display("FAIL rdwr_write addr=%h got c_write=%b expected 1", a, c_write); end
    end
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
    tests++;
    bad = wr_log.size() != (ev ? 4 : 0);
    if (!bad && ev) for (int k = 0; k < 4; k++) if (wr_log[k] !== {ot, ix, 2'(k), 1'b0}) bad = 1;
    if (bad) begin fails++; $display("FAIL writeback addr=%h got %0d writes (first %h) expected %0d from tag %h", a, wr_log.size(), wr_log.size() ? wr_log[0] : 16'h0, ev ? 4 : 0, ot); end
    tests++;
    bad = rd_log.size() != (hw < 0 ? 4 : 0);
    if (!bad && hw < 0) for (int k = 0; k < 4; k++) if (rd_log[k] !== {tg, ix, 2'(k), 1'b0}) bad = 1;
    if (bad) begin fails++; $display("FAIL refill_reads addr=%h got %0d reads (first %h) expected %0d", a, rd_log.size(), rd_log.size() ? rd_log[0] : 16'h0, hw < 0 ? 4 : 0); end
    if (hw < 0) begin
      tests++;
      if (!cv[v][ix] || ctg[v][ix] !== tg) begin fails++; $display("FAIL victim_way addr=%h way %0d holds tag %h valid %b expected tag %h", a, v, ctg[v][ix], cv[v][ix], tg); end
      rt[v][ix] = tg;
      rv[v][ix] = 1'b1;
      rdy[v][ix] = w;
    end else if (w) rdy[hw][ix] = 1'b1;
    if (w) gold[a[15:1]] = d;
    rvw = !rvw;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (|{data_out, done, stall, cache_hit, c_en, c_index, c_offset, c_tag_in, c_data_in, c_comp, c_write, c_valid_in, m_addr, m_data_in, m_wr, m_rd} !== 1'b0) begin
      fails++; $display("FAIL reset_outputs got nonzero outputs expected all zero");
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_read;
    op(0, 0, 16'h1234, 16'h0, 0);
    op(0, 0, 16'h1234, 16'h0, 0);
  endtask

  task automatic test_victim;
    op(0, 0, 16'h1A30, 16'h0, 0);
    op(0, 0, 16'h2230, 16'h0, 0);
    op(0, 0, 16'h2A30, 16'h0, 0);
  endtask

  task automatic test_dirty;
    op(1, 0, 16'h1234, 16'hBEEF, 0);
    op(0, 0, 16'h3234, 16'h0, 0);
    op(0, 0, 16'h3A34, 16'h0, 0);
    tests++;
    if (mem[16'h1234 >> 1] !== 16'hBEEF) begin fails++; $display("FAIL dirty_mem got %h expected BEEF", mem[16'h1234 >> 1]); end
    op(0, 0, 16'h1234, 16'h0, 0);
  endtask

  task automatic test_mstall;
    op(1, 0, 16'h1236, 16'h1111, 0);
    op(1, 0, 16'h3A30, 16'h2222, 0);
    smask = (32'd1 << 2) | (32'd1 << 3) | (32'd1 << 9) | (32'd1 << 10);
    sen = 1'b1;
    op(0, 0, 16'h4230, 16'h0, 4);
    sen = 1'b0;
  endtask

  task automatic test_rdwr_both;
    op(1, 1, 16'h4230, 16'hA5A5, 0);
    op(0, 0, 16'h4230, 16'h0, 0);
  endtask

  task automatic test_reset_mid;
    int f0;
    rd = 1'b1;
    addr = 16'h0500;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (|{data_out, done, stall, cache_hit, c_en, c_index, c_offset, c_tag_in, c_data_in, c_comp, c_write, c_valid_in, m_addr, m_data_in, m_wr, m_rd} !== 1'b0) begin
      fails++; $display("FAIL reset_mid_outputs got nonzero outputs expected all zero");
    end
    f0 = fc;
    repeat (4) @(negedge clk);
    tests++;
    if (fc != f0 || cv[0][8'hA0] || cv[1][8'hA0]) begin fails++; $display("FAIL reset_mid_fill got %0d fill writes expected 0", fc - f0); end
    rvw = 1'b0;
    op(0, 0, 16'h0500, 16'h0, 0);
  endtask

  task automatic test_random;
    logic [7:0] ix;
    logic [4:0] tg;
    logic [1:0] wd;
    bit w, both;
    for (int n = 0; n < 150; n++) begin
      ix = ($urandom_range(0, 1) == 0) ? 8'h46 : 8'h11;
      tg = 5'($urandom_range(0, 4));
      wd = 2'($urandom_range(0, 3));
      w = $urandom_range(0, 2) == 0;
      both = w && $urandom_range(0, 3) == 0;
      op(w, both, {tg, ix, wd, 1'b0}, 16'($urandom), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom);
      gold[i] = mem[i];
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++) begin
        cv[i][j] = 1'b0;
        cdy[i][j] = 1'b0;
        ctg[i][j] = '0;
        rv[i][j] = 1'b0;
        rdy[i][j] = 1'b0;
        rt[i][j] = '0;
        for (int k = 0; k < 4; k++) cdt[i][j][k] = '0;
      end
    @(negedge clk);
    test_reset;
    test_cold_read;
    test_victim;
    test_dirty;
    test_mstall;
    test_rdwr_both;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1);
  end
endmodule
